// File: rtl/bank_wl_sequencer.sv
// Multi-bank word-line sequencer: accepts row requests, selects the bank and pulses one-hot
// word lines with programmed setup / pulse / recovery timing, optionally bursting over consecutive rows.
module bank_wl_sequencer #(
    parameter int ROW_W     = 10,
    parameter int BANKS     = 4,
    parameter int BANK_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 4,
    parameter int RECOV_CYC = 1,
    parameter int BURST_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [BANK_W-1:0]       req_bank,
    input  logic [ROW_W-1:0]        req_row,
    input  logic [BURST_W-1:0]      req_burst,
    input  logic                    WL_enable,
    output logic [(2**ROW_W)-1:0]   wl,
    output logic [BANKS-1:0]        bank_sel,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int ROWS    = 2**ROW_W;
    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > RECOV_CYC) ? SETUP_CYC : RECOV_CYC) :
                             ((PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W+1)'(BANKS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ASSERT  = 3'd2,
        RECOVER = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_next_s;
    logic [BANK_W-1:0]    bank_q;
    logic [ROW_W-1:0]     row_q;
    logic [BURST_W-1:0]   rem_q;
    logic                 done_r;
    logic                 err_r;
    logic                 accept_s;
    logic                 step_s;
    logic                 done_next_s;
    logic                 err_next_s;
    logic                 bank_ok_s;
    logic                 bank_active_s;

    // Widened compare so BANKS == 2**BANK_W does not wrap to zero.
    assign bank_ok_s = ({1'b0, req_bank} < BANK_LIMIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, counter and completion decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        done_next_s  = 1'b0;
        err_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = bank_ok_s ? SETUP : FAULT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
                    state_next_s = ASSERT;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            ASSERT: begin
                // Only gated-on cycles count toward the pulse width.
                if (!WL_enable) begin
                    cnt_next_s = cnt_r;
                end else if (cnt_r == CNT_W'(PULSE_CYC - 1)) begin
                    state_next_s = RECOVER;
                    cnt_next_s   = '0;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_r != CNT_W'(RECOV_CYC - 1)) begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end else if (rem_q != '0) begin
                    cnt_next_s   = '0;
                    step_s       = 1'b1;
                    state_next_s = ASSERT;
                end else begin
                    cnt_next_s   = '0;
                    done_next_s  = 1'b1;
                    state_next_s = IDLE;
                end
            end
            FAULT: begin
                done_next_s  = 1'b1;
                err_next_s   = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                cnt_next_s   = '0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Request latch, burst stepping, counter and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            bank_q <= '0;
            row_q  <= '0;
            rem_q  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            done_r <= done_next_s;
            err_r  <= err_next_s;
            if (accept_s) begin
                bank_q <= req_bank;
                row_q  <= req_row;
                rem_q  <= req_burst;
            end else if (step_s) begin
                row_q  <= row_q + ROW_W'(1);
                rem_q  <= rem_q - BURST_W'(1);
            end else begin
                row_q  <= row_q;
                rem_q  <= rem_q;
            end
        end
    end

    assign bank_active_s = (state_r == SETUP) || (state_r == ASSERT) || (state_r == RECOVER);

    // One-hot bank select and word-line decode, forced low while reset is held.
    always_comb begin
        bank_sel = '0;
        wl       = '0;
        for (int i = 0; i < BANKS; i++) begin
            bank_sel[i] = bank_active_s && !rst && (bank_q == BANK_W'(i));
        end
        for (int i = 0; i < ROWS; i++) begin
            wl[i] = (state_r == ASSERT) && WL_enable && !rst && (row_q == ROW_W'(i));
        end
    end

    assign req_ready = (state_r == IDLE) && !rst;
    assign busy      = (state_r != IDLE) && !rst;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_bank_wl_sequencer.sv
// Randomized scoreboard bench for bank_wl_sequencer (BANKS overridden to 3 so invalid banks exist).
module tb_bank_wl_sequencer;

    localparam int ROW_W     = 10;
    localparam int ROWS      = 1024;
    localparam int BANKS     = 3;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 4;
    localparam int RECOV_CYC = 1;

    typedef struct {
        int row;
        int bsel;
        bit busy;
        bit done;
        bit err;
        bit ready;
    } exp_t;

    typedef struct {
        int bank;
        int row;
        int burst;
        int mode;       // 0: enable always on, 1: random enable, 2: 3-cycle pause mid-pulse
        bit b2b;        // presented while the previous request is still running
        bit immediate;  // must be accepted at the first edge it is offered
    } txn_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [3:0]        req_burst;
    logic              WL_enable;
    logic [ROWS-1:0]   wl;
    logic [BANKS-1:0]  bank_sel;
    logic              busy;
    logic              done;
    logic              err;

    exp_t exp_q[$];
    txn_t txq[$];
    bit   en_cur[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   abort  = 1'b0;

    bank_wl_sequencer #(
        .ROW_W(ROW_W), .BANKS(BANKS), .BANK_W(2), .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC), .RECOV_CYC(RECOV_CYC), .BURST_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_row(req_row), .req_burst(req_burst),
        .WL_enable(WL_enable), .wl(wl), .bank_sel(bank_sel), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Expected per-cycle trace of one request, derived from the timing rules.
    task automatic build_model(input txn_t t);
        exp_t r;
        int   bsel;
        int   highs;
        int   pause;
        int   rr;
        bit   e;
        en_cur.delete();
        if (t.bank >= BANKS) begin
            r = '{row: -1, bsel: 0, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
            exp_q.push_back(r);
            en_cur.push_back(1'($urandom_range(0, 1)));
            r = '{row: -1, bsel: 0, busy: 1'b0, done: 1'b1, err: 1'b1, ready: 1'b1};
            exp_q.push_back(r);
        end else begin
            bsel  = 1 << t.bank;
            pause = (t.mode == 2) ? 3 : 0;
            for (int s = 0; s < SETUP_CYC; s++) begin
                r = '{row: -1, bsel: bsel, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
                exp_q.push_back(r);
                en_cur.push_back(1'($urandom_range(0, 1)));
            end
            for (int k = 0; k <= t.burst; k++) begin
                rr    = (t.row + k) % ROWS;
                highs = 0;
                while (highs < PULSE_CYC) begin
                    if (t.mode == 0) begin
                        e = 1'b1;
                    end else if (t.mode == 2) begin
                        if (pause > 0 && highs == 2) begin
                            e = 1'b0;
                            pause--;
                        end else begin
                            e = 1'b1;
                        end
                    end else begin
                        e = ($urandom_range(0, 4) != 0);
                    end
                    en_cur.push_back(e);
                    r = '{row: (e ? rr : -1), bsel: bsel, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
                    exp_q.push_back(r);
                    if (e) highs++;
                end
                for (int s = 0; s < RECOV_CYC; s++) begin
                    r = '{row: -1, bsel: bsel, busy: 1'b1, done: 1'b0, err: 1'b0, ready: 1'b0};
                    exp_q.push_back(r);
                    en_cur.push_back(1'($urandom_range(0, 1)));
                end
            end
            r = '{row: -1, bsel: 0, busy: 1'b0, done: 1'b1, err: 1'b0, ready: 1'b1};
            exp_q.push_back(r);
        end
    endtask

    task automatic present(input txn_t t);
        req_valid = 1'b1;
        req_bank  = 2'(t.bank);
        req_row   = 10'(t.row);
        req_burst = 4'(t.burst);
    endtask

    // Wait for acceptance; returns the number of offered cycles refused, -1 on timeout.
    task automatic wait_accept(output int waited);
        bit rdy;
        waited = 0;
        @(negedge clk);
        rdy = req_ready;
        while (!rdy && waited < 50) begin
            waited++;
            @(negedge clk);
            rdy = req_ready;
        end
        if (!rdy) begin
            waited = -1;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_list();
        txn_t t;
        int   waited;
        bit   presented;
        presented = 1'b0;
        while (txq.size() > 0 && !abort) begin
            t = txq.pop_front();
            build_model(t);
            if (!presented) present(t);
            wait_accept(waited);
            if (waited < 0) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout bank=%0d row=%0d req_ready never high within 50 cycles", t.bank, t.row);
                abort = 1'b1;
                txq.delete();
                exp_q.delete();
            end else begin
                if (t.b2b || t.immediate) begin
                    checks++;
                    if (waited != 0) begin
                        errors++;
                        $display("FAIL accept_latency bank=%0d row=%0d refused_cycles=%0d expected 0", t.bank, t.row, waited);
                    end
                end
                if (txq.size() > 0 && txq[0].b2b) begin
                    present(txq[0]);
                    presented = 1'b1;
                end else begin
                    req_valid = 1'b0;
                    req_bank  = 2'($urandom);
                    req_row   = 10'($urandom);
                    req_burst = 4'($urandom);
                    presented = 1'b0;
                end
                foreach (en_cur[k]) begin
                    WL_enable = en_cur[k];
                    @(posedge clk);
                    #1;
                end
                if (!presented) begin
                    repeat ($urandom_range(0, 2)) begin
                        WL_enable = 1'($urandom);
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
        req_valid = 1'b0;
    endtask

    // Monitor: pops one expected cycle for every cycle the DUT shows activity.
    initial begin
        exp_t r;
        int   act_ones;
        int   act_row;
        int   exp_ones;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && (busy || done || err || (wl != '0) || (bank_sel != '0))) begin
                act_ones = 0;
                act_row  = -1;
                for (int i = 0; i < ROWS; i++) begin
                    if (wl[i]) begin
                        act_ones++;
                        act_row = i;
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_activity busy=%b done=%b err=%b bank_sel=%b wl_row=%0d expected idle",
                             busy, done, err, bank_sel, act_row);
                end else begin
                    r = exp_q.pop_front();
                    exp_ones = (r.row >= 0) ? 1 : 0;
                    if (act_ones != exp_ones || act_row != r.row || bank_sel != 3'(r.bsel) ||
                        busy != r.busy || done != r.done || err != r.err || req_ready != r.ready) begin
                        errors++;
                        $display("FAIL cycle_check got wl_row=%0d wl_ones=%0d bank_sel=%b busy=%b done=%b err=%b ready=%b expected wl_row=%0d bank_sel=%b busy=%b done=%b err=%b ready=%b",
                                 act_row, act_ones, bank_sel, busy, done, err, req_ready,
                                 r.row, 3'(r.bsel), r.busy, r.done, r.err, r.ready);
                    end
                end
            end
        end
    end

    initial begin
        txn_t t;
        int   waited;
        int   n;
        bit   seen;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_bank  = 2'd2;
        req_row   = 10'd37;
        req_burst = 4'd0;
        WL_enable = 1'b1;

        repeat (3) @(negedge clk);
        checks++;
        if (wl != '0 || bank_sel != '0 || busy || done || err || req_ready) begin
            errors++;
            $display("FAIL reset_outputs got bank_sel=%b busy=%b done=%b err=%b ready=%b wl_zero=%b expected all 0",
                     bank_sel, busy, done, err, req_ready, (wl == '0));
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        t = '{bank: 2, row: 37,   burst: 0, mode: 0, b2b: 1'b0, immediate: 1'b1}; txq.push_back(t);
        t = '{bank: 1, row: 1023, burst: 2, mode: 0, b2b: 1'b0, immediate: 1'b0}; txq.push_back(t);
        t = '{bank: 0, row: 100,  burst: 0, mode: 2, b2b: 1'b0, immediate: 1'b0}; txq.push_back(t);
        t = '{bank: 3, row: 7,    burst: 0, mode: 0, b2b: 1'b0, immediate: 1'b0}; txq.push_back(t);
        t = '{bank: 0, row: 5,    burst: 1, mode: 0, b2b: 1'b1, immediate: 1'b0}; txq.push_back(t);
        t = '{bank: 2, row: 500,  burst: 0, mode: 1, b2b: 1'b1, immediate: 1'b0}; txq.push_back(t);
        run_list();

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL directed_drain got pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end

        // Reset asserted in the middle of a word-line pulse.
        t = '{bank: 2, row: 37, burst: 0, mode: 0, b2b: 1'b0, immediate: 1'b0};
        present(t);
        wait_accept(waited);
        req_valid = 1'b0;
        WL_enable = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            seen = wl[37];
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_pulse_setup got wl37=0 expected wl37=1 within 10 cycles");
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wl != '0 || bank_sel != '0 || busy || done || err || req_ready) begin
            errors++;
            $display("FAIL reset_mid_pulse got bank_sel=%b busy=%b done=%b err=%b ready=%b wl_zero=%b expected all 0",
                     bank_sel, busy, done, err, req_ready, (wl == '0));
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        t = '{bank: 2, row: 5, burst: 0, mode: 0, b2b: 1'b0, immediate: 1'b1};
        txq.push_back(t);
        for (int i = 0; i < 40; i++) begin
            t.bank      = $urandom_range(0, 3);
            t.row       = $urandom_range(0, ROWS - 1);
            t.burst     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            t.mode      = $urandom_range(0, 1);
            t.b2b       = 1'($urandom_range(0, 1));
            t.immediate = 1'b0;
            txq.push_back(t);
        end
        run_list();

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain got pending=%0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
